// File: rtl/vscale_dmem_responder.sv
// Scratchpad data-memory slave for the vscale dmem port: accepts DX-cycle requests,
// holds dmem_wait for WAIT_CYCLES wait states, then presents exactly one response cycle.
`ifndef XPR_LEN
`define XPR_LEN 32
`endif
`ifndef MEM_TYPE_WIDTH
`define MEM_TYPE_WIDTH 3
`endif

module vscale_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dmem_en,
    input  logic                       dmem_wen,
    input  logic [`MEM_TYPE_WIDTH-1:0] dmem_size,
    input  logic [`XPR_LEN-1:0]        dmem_addr,
    input  logic [`XPR_LEN-1:0]        dmem_wdata_delayed,
    output logic [`XPR_LEN-1:0]        dmem_rdata,
    output logic                       dmem_wait,
    output logic                       dmem_badmem_e
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [`MEM_TYPE_WIDTH-1:0] SZ_B = `MEM_TYPE_WIDTH'(0);
    localparam logic [`MEM_TYPE_WIDTH-1:0] SZ_H = `MEM_TYPE_WIDTH'(1);
    localparam logic [`MEM_TYPE_WIDTH-1:0] SZ_W = `MEM_TYPE_WIDTH'(2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                      state_reg, state_next;
    logic [3:0]                  cnt_reg, cnt_next;
    logic [IDX_W-1:0]            idx_reg;
    logic [1:0]                  lane_reg;
    logic [`MEM_TYPE_WIDTH-1:0]  size_reg;
    logic                        wen_reg;
    logic                        bad_reg;

    logic [31:0]                 mem [DEPTH_WORDS];

    logic [31:0]                 offset;
    logic                        out_of_range;
    logic                        misaligned;
    logic                        req_bad;
    logic                        accept;
    logic [3:0]                  be_mask;
    logic [31:0]                 rd_word;
    logic [31:0]                 wr_word;
    logic                        commit;

    // BASE_ADDR is span-aligned, so offset[1:0] equals the byte lane of the address.
    assign offset       = dmem_addr - BASE_ADDR;
    assign out_of_range = {1'b0, offset} >= SPAN_BYTES;

    always_comb begin
        misaligned = 1'b1;
        case (dmem_size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = offset[0];
            SZ_W:    misaligned = |offset[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    assign req_bad = out_of_range | misaligned;
    assign accept  = dmem_en && ((state_reg == ST_IDLE) || (state_reg == ST_RESP));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                    cnt_next   = CNT_LOAD;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            idx_reg   <= '0;
            lane_reg  <= 2'd0;
            size_reg  <= '0;
            wen_reg   <= 1'b0;
            bad_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                idx_reg  <= offset[IDX_W+1:2];
                lane_reg <= offset[1:0];
                size_reg <= dmem_size;
                wen_reg  <= dmem_wen;
                bad_reg  <= req_bad;
            end
        end
    end

    always_comb begin
        be_mask = 4'b0000;
        case (size_reg)
            SZ_B:    be_mask = 4'b0001 << lane_reg;
            SZ_H:    be_mask = 4'b0011 << {lane_reg[1], 1'b0};
            SZ_W:    be_mask = 4'b1111;
            default: be_mask = 4'b0000;
        endcase
    end

    assign rd_word = mem[idx_reg];

    // Store data arrives only in the response cycle, so merge lanes against the current word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wr_word[8*gi +: 8] = be_mask[gi] ? dmem_wdata_delayed[8*gi +: 8]
                                                    : rd_word[8*gi +: 8];
        end
    endgenerate

    assign commit = (state_reg == ST_RESP) && wen_reg && !bad_reg;

    always_ff @(posedge clk) begin
        if (commit) begin
            mem[idx_reg] <= wr_word;
        end
    end

    assign dmem_wait     = (state_reg == ST_WAIT);
    assign dmem_badmem_e = (state_reg == ST_RESP) && bad_reg;
    assign dmem_rdata    = ((state_reg == ST_RESP) && !wen_reg && !bad_reg) ? rd_word : 32'd0;

`ifndef SYNTHESIS
    a_en_known: assert property (@(posedge clk) disable iff (reset) !$isunknown(dmem_en))
        else $error("dmem_en is unknown while reset is low");
`endif

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Bench for vscale_dmem_responder: three instances (0, 2 and 3 wait states) driven by
// directed vectors, hand-written corner sequences and a randomized byte-level model.
`ifndef XPR_LEN
`define XPR_LEN 32
`endif
`ifndef MEM_TYPE_WIDTH
`define MEM_TYPE_WIDTH 3
`endif

module tb_vscale_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en [3];
    logic        wen = 1'b0;
    logic [2:0]  size = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata [3];
    logic        wait_o [3];
    logic        bad_o [3];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    vscale_dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .dmem_en(en[0]), .dmem_wen(wen), .dmem_size(size),
        .dmem_addr(addr), .dmem_wdata_delayed(wdata), .dmem_rdata(rdata[0]),
        .dmem_wait(wait_o[0]), .dmem_badmem_e(bad_o[0]));

    vscale_dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) dut1 (
        .clk(clk), .reset(reset), .dmem_en(en[1]), .dmem_wen(wen), .dmem_size(size),
        .dmem_addr(addr), .dmem_wdata_delayed(wdata), .dmem_rdata(rdata[1]),
        .dmem_wait(wait_o[1]), .dmem_badmem_e(bad_o[1]));

    vscale_dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) dut2 (
        .clk(clk), .reset(reset), .dmem_en(en[2]), .dmem_wen(wen), .dmem_size(size),
        .dmem_addr(addr), .dmem_wdata_delayed(wdata), .dmem_rdata(rdata[2]),
        .dmem_wait(wait_o[2]), .dmem_badmem_e(bad_o[2]));

    function automatic int wc_of(input int d);
        case (d)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge inside the response cycle so the
    // next call issues a back-to-back request.
    task automatic xact(input int d, input logic w, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_bad,
                        input string nm, input bit hold_en);
        en[d] = 1'b1;
        wen   = w;
        size  = sz;
        addr  = a;
        @(negedge clk);
        if (!hold_en) en[d] = 1'b0;
        for (int i = 0; i < wc_of(d); i++) begin
            chk({nm, " wait"}, 32'(wait_o[d]), 32'd1);
            @(negedge clk);
        end
        en[d] = 1'b0;
        wdata = wd;
        chk({nm, " wait_resp"}, 32'(wait_o[d]), 32'd0);
        chk({nm, " rdata"}, rdata[d], exp_rd);
        chk({nm, " badmem"}, 32'(bad_o[d]), 32'(exp_bad));
        $display("txn %s dut%0d wen=%0b size=%0d addr=%h wdata=%h rdata=%h bad=%0b",
                 nm, d, w, sz, a, wd, rdata[d], bad_o[d]);
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_bad;
        string       nm;
    } vec_t;

    vec_t tbl [$];
    logic [7:0] mb [128];

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        for (int d = 0; d < 3; d++) en[d] = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset wait dut%0d", d), 32'(wait_o[d]), 32'd0);
            chk($sformatf("reset rdata dut%0d", d), rdata[d], 32'd0);
            chk($sformatf("reset badmem dut%0d", d), 32'(bad_o[d]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Store then back-to-back load with zero wait states.
        xact(0, 1'b1, 3'd2, 32'h40, 32'hDEADBEEF, 32'd0, 1'b0, "sw_40", 1'b0);
        xact(0, 1'b0, 3'd2, 32'h40, 32'd0, 32'hDEADBEEF, 1'b0, "lw_40", 1'b0);
        @(negedge clk);

        dut0.mem[16]   = 32'h11223344;
        dut0.mem[1023] = 32'h0BADF00D;
        tbl.push_back('{1'b1, 3'd0, 32'h42,   32'hAAAAAAAA, 32'h0,        1'b0, "sb_42"});
        tbl.push_back('{1'b0, 3'd2, 32'h40,   32'h0,        32'h11AA3344, 1'b0, "lw_after_sb"});
        tbl.push_back('{1'b1, 3'd1, 32'h42,   32'h55665566, 32'h0,        1'b0, "sh_42"});
        tbl.push_back('{1'b0, 3'd2, 32'h40,   32'h0,        32'h55663344, 1'b0, "lw_after_sh"});
        tbl.push_back('{1'b0, 3'd1, 32'h41,   32'h0,        32'h0,        1'b1, "lh_41_misal"});
        tbl.push_back('{1'b0, 3'd0, 32'h43,   32'h0,        32'h55663344, 1'b0, "lb_43_fullword"});
        tbl.push_back('{1'b0, 3'd1, 32'h42,   32'h0,        32'h55663344, 1'b0, "lh_42"});
        tbl.push_back('{1'b1, 3'd2, 32'h1000, 32'h12345678, 32'h0,        1'b1, "sw_oob"});
        tbl.push_back('{1'b0, 3'd2, 32'hFFC,  32'h0,        32'h0BADF00D, 1'b0, "lw_last_word"});
        tbl.push_back('{1'b0, 3'd2, 32'h3002, 32'h0,        32'h0,        1'b1, "lw_oob_misal"});
        tbl.push_back('{1'b0, 3'd3, 32'h40,   32'h0,        32'h0,        1'b1, "size3_illegal"});
        tbl.push_back('{1'b1, 3'd0, 32'h41,   32'h77777777, 32'h0,        1'b0, "sb_41"});
        tbl.push_back('{1'b0, 3'd2, 32'h40,   32'h0,        32'h55667744, 1'b0, "lw_after_sb41"});
        tbl.push_back('{1'b1, 3'd2, 32'h42,   32'hFFFFFFFF, 32'h0,        1'b1, "sw_misal"});
        tbl.push_back('{1'b0, 3'd2, 32'h40,   32'h0,        32'h55667744, 1'b0, "lw_unchanged"});
        for (int i = 0; i < tbl.size(); i++) begin
            xact(0, tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].wd, tbl[i].exp_rd, tbl[i].exp_bad,
                 tbl[i].nm, 1'b0);
        end
        @(negedge clk);

        // Three wait states with dmem_en held high through WAIT: only one response.
        dut2.mem[4] = 32'h0F0E0D0C;
        xact(2, 1'b0, 3'd2, 32'h10, 32'd0, 32'h0F0E0D0C, 1'b0, "lw_wc3_held", 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wc3 no_extra wait", 32'(wait_o[2]), 32'd0);
            chk("wc3 no_extra rdata", rdata[2], 32'd0);
        end
        xact(2, 1'b0, 3'd2, 32'h10, 32'd0, 32'h0F0E0D0C, 1'b0, "lw_wc3", 1'b0);
        @(negedge clk);

        // Asynchronous reset during the first WAIT cycle drops a pending store.
        dut1.mem[8] = 32'h12345678;
        en[1] = 1'b1;
        wen   = 1'b1;
        size  = 3'd2;
        addr  = 32'h20;
        @(negedge clk);
        en[1] = 1'b0;
        chk("abort wait_before", 32'(wait_o[1]), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort wait_async", 32'(wait_o[1]), 32'd0);
        chk("abort rdata_async", rdata[1], 32'd0);
        chk("abort badmem_async", 32'(bad_o[1]), 32'd0);
        wdata = 32'hCAFEF00D;
        $display("txn abort dut1 sw addr=00000020 wdata=cafef00d reset asserted in WAIT");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort idle wait", 32'(wait_o[1]), 32'd0);
        xact(1, 1'b0, 3'd2, 32'h20, 32'd0, 32'h12345678, 1'b0, "lw_after_abort", 1'b0);
        @(negedge clk);

        // Randomized traffic against a byte-addressed model of the first 128 bytes.
        for (int i = 0; i < 32; i++) begin
            logic [31:0] v;
            v = $urandom;
            dut1.mem[i] = v;
            for (int k = 0; k < 4; k++) mb[4*i+k] = v[8*k +: 8];
        end
        for (int n = 0; n < 150; n++) begin
            logic        w, isbad;
            logic [2:0]  sz;
            logic [31:0] a, wd, exp;
            logic [7:0]  b;
            logic [15:0] h;
            int          nbytes;
            w  = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0)
                a = ($urandom_range(0, 1) == 0) ? 32'h1000 + 32'($urandom_range(0, 127))
                                                : 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
            else
                a = 32'($urandom_range(0, 127));
            b = 8'($urandom);
            h = 16'($urandom);
            case (sz)
                3'd0:    wd = {4{b}};
                3'd1:    wd = {2{h}};
                default: wd = $urandom;
            endcase
            isbad = (a >= 32'd4096) || (sz == 3'd1 && a % 2 != 0) || (sz == 3'd2 && a % 4 != 0)
                    || (sz > 3'd2);
            nbytes = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
            exp = 32'd0;
            if (!isbad && w) begin
                for (int k = 0; k < nbytes; k++) mb[a + k] = wd[8*((a + k) % 4) +: 8];
            end else if (!isbad) begin
                for (int k = 0; k < 4; k++) exp[8*k +: 8] = mb[(a / 4) * 4 + k];
            end
            xact(1, w, sz, a, wd, exp, isbad, $sformatf("rnd%0d", n), 1'b0);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
